// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int DBITS = 32;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DBITS);

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negate: dout = neg ? -din : din.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Divide support is built only when the macro MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Dbits = DBITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [Dbits-1:0] srcA,
  input  logic [Dbits-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [Dbits-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [Dbits-1:0] hi,
  output logic [Dbits-1:0] lo
);

  localparam int CW = cnt_width(Dbits);
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_t             state;
  state_t             state_next;
  op_t                op_in;
  logic [CW-1:0]      cnt;
  logic [2*Dbits-1:0] acc;
  logic [2*Dbits-1:0] step;
  logic [2*Dbits-1:0] prod_fix;
  logic [Dbits-1:0]   opnd_b;
  logic [Dbits-1:0]   abs_a;
  logic [Dbits-1:0]   abs_b;
  logic [Dbits-1:0]   res_hi;
  logic [Dbits-1:0]   res_lo;
  logic [Dbits:0]     mul_sum;
  logic               sign_a;
  logic               sign_b;
  logic               neg_lo;
`ifdef MULDIV_DIV_EN
  logic               div_r;
  logic               neg_hi;
  logic [Dbits:0]     div_diff;
  logic [Dbits-1:0]   quot_fix;
  logic [Dbits-1:0]   rem_fix;
`endif

  assign op_in  = op_t'(op);
  assign sign_a = op_is_signed(op_in) & srcA[Dbits-1];
  assign sign_b = op_is_signed(op_in) & srcB[Dbits-1];

  muldiv_negate #(.W(Dbits)) u_abs_a (.neg(sign_a), .din(srcA), .dout(abs_a));
  muldiv_negate #(.W(Dbits)) u_abs_b (.neg(sign_b), .din(srcB), .dout(abs_b));
  muldiv_negate #(.W(2*Dbits)) u_fix_prod (.neg(neg_lo), .din(acc), .dout(prod_fix));

`ifdef MULDIV_DIV_EN
  muldiv_negate #(.W(Dbits)) u_fix_quot (
    .neg (neg_lo),
    .din (acc[Dbits-1:0]),
    .dout(quot_fix)
  );
  muldiv_negate #(.W(Dbits)) u_fix_rem (
    .neg (neg_hi),
    .din (acc[2*Dbits-1:Dbits]),
    .dout(rem_fix)
  );
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*Dbits-1:Dbits]} + (acc[0] ? {1'b0, opnd_b} : '0);
    step    = {mul_sum, acc[Dbits-1:1]};
`ifdef MULDIV_DIV_EN
    div_diff = acc[2*Dbits-1:Dbits-1] - {1'b0, opnd_b};
    if (div_r) begin
      if (div_diff[Dbits]) begin
        step = {acc[2*Dbits-2:0], 1'b0};
      end else begin
        step = {div_diff[Dbits-1:0], acc[Dbits-2:0], 1'b1};
      end
    end
`endif
  end

  always_comb begin
    res_hi = prod_fix[2*Dbits-1:Dbits];
    res_lo = prod_fix[Dbits-1:0];
`ifdef MULDIV_DIV_EN
    if (div_r) begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end
`endif
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (op_is_div(op_in) && !DIV_EN) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(Dbits - 1)) begin
          state_next = S_FIXUP;
        end
      end
      S_FIXUP: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A zero divisor keeps the quotient unsigned so LO reads all ones and HI returns the dividend.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd_b <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_DIV_EN
      div_r  <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt    <= '0;
            acc    <= {{Dbits{1'b0}}, abs_a};
            opnd_b <= abs_b;
            neg_lo <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
            div_r  <= op_is_div(op_in);
            neg_hi <= sign_a;
            if (op_is_div(op_in) && (srcB == '0)) begin
              neg_lo <= 1'b0;
            end
`endif
          end
        end
        S_RUN: begin
          acc <= step;
          cnt <= cnt + CW'(1);
        end
        S_FIXUP: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit; follows MULDIV_DIV_EN for divide expectations.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int LAT_FULL = 34;
  localparam int MAX_WAIT = 80;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[15];

  muldiv_unit #(.Dbits(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    srcA  = 32'hDEAD_0000;
    srcB  = 32'h0000_BEEF;
  endtask

  task automatic wait_done(input int start_count, output int lat, output int busy_n,
                           output logic [31:0] got_hi, output logic [31:0] got_lo);
    bit seen;
    seen   = 1'b0;
    lat    = start_count;
    busy_n = 0;
    got_hi = 'x;
    got_lo = 'x;
    while (!seen && lat < MAX_WAIT) begin
      @(negedge clock);
      lat++;
      if (busy) busy_n++;
      if (done) begin
        seen   = 1'b1;
        got_hi = hi;
        got_lo = lo;
        check_output("busy_in_done", 64'(busy), 64'(0));
      end
    end
    if (!seen) check_output("done_timeout", 64'(0), 64'(1));
    @(negedge clock);
    check_output("done_single_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    int          lat;
    int          busy_n;
    logic [31:0] got_hi;
    logic [31:0] got_lo;
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          e_lat;
    bit          is_div;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
    vecs[7]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
    vecs[8]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[12] = '{OP_DIVU,  32'h00000008, 32'h00000002, 32'h00000000, 32'h00000004};
    vecs[13] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[14] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_done", 64'(done), 64'(0));
    check_output("reset_hi", 64'(hi), 64'(0));
    check_output("reset_lo", 64'(lo), 64'(0));
    reset = 1'b0;

    // Without the divide datapath, DIV/DIVU finish at once and leave HI/LO alone.
    model_hi = '0;
    model_lo = '0;
    for (int i = 0; i < 15; i++) begin
      is_div = (vecs[i].op == OP_DIV) || (vecs[i].op == OP_DIVU);
      if (is_div && !DIV_EN) begin
        e_hi  = model_hi;
        e_lo  = model_lo;
        e_lat = 1;
      end else begin
        e_hi  = vecs[i].exp_hi;
        e_lo  = vecs[i].exp_lo;
        e_lat = LAT_FULL;
      end
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, busy_n, got_hi, got_lo);
      check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(e_lat));
      check_output($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(e_lat - 1));
      check_output($sformatf("vec%0d_hi", i), 64'(got_hi), 64'(e_hi));
      check_output($sformatf("vec%0d_lo", i), 64'(got_lo), 64'(e_lo));
      model_hi = e_hi;
      model_lo = e_lo;
    end

    // Second start while busy must be ignored.
    apply_stimulus(OP_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clock);
    start = 1'b1;
    op    = OP_MULTU;
    srcA  = 32'd9;
    srcB  = 32'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(4, lat, busy_n, got_hi, got_lo);
    check_output("ignored_start_latency", 64'(lat), 64'(LAT_FULL));
    check_output("ignored_start_hi", 64'(got_hi), 64'(0));
    check_output("ignored_start_lo", 64'(got_lo), 64'(32'h0000000C));

    // MTHI / MTLO in IDLE.
    @(negedge clock);
    hi_we = 1'b1;
    wdata = 32'h12345678;
    @(posedge clock);
    #1;
    hi_we = 1'b0;
    @(negedge clock);
    check_output("mthi_hi", 64'(hi), 64'(32'h12345678));
    check_output("mthi_lo_kept", 64'(lo), 64'(32'h0000000C));
    lo_we = 1'b1;
    wdata = 32'h0BADF00D;
    @(posedge clock);
    #1;
    lo_we = 1'b0;
    @(negedge clock);
    check_output("mtlo_lo", 64'(lo), 64'(32'h0BADF00D));
    check_output("mtlo_hi_kept", 64'(hi), 64'(32'h12345678));
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(posedge clock);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clock);
    check_output("mthilo_hi", 64'(hi), 64'(32'hA5A5A5A5));
    check_output("mthilo_lo", 64'(lo), 64'(32'hA5A5A5A5));

    // Writes while busy are dropped.
    apply_stimulus(OP_MULTU, 32'd2, 32'd3);
    @(negedge clock);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clock);
    check_output("busy_write_hi", 64'(hi), 64'(32'hA5A5A5A5));
    check_output("busy_write_lo", 64'(lo), 64'(32'hA5A5A5A5));
    wait_done(2, lat, busy_n, got_hi, got_lo);
    check_output("busy_write_res_hi", 64'(got_hi), 64'(0));
    check_output("busy_write_res_lo", 64'(got_lo), 64'(32'h00000006));

    // Start together with MTHI: write lands now, result overwrites later.
    @(negedge clock);
    start = 1'b1;
    op    = OP_MULTU;
    srcA  = 32'd5;
    srcB  = 32'd5;
    hi_we = 1'b1;
    wdata = 32'h11111111;
    @(posedge clock);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    @(negedge clock);
    check_output("start_mthi_hi", 64'(hi), 64'(32'h11111111));
    check_output("start_mthi_busy", 64'(busy), 64'(1));
    wait_done(1, lat, busy_n, got_hi, got_lo);
    check_output("start_mthi_latency", 64'(lat), 64'(LAT_FULL));
    check_output("start_mthi_res_hi", 64'(got_hi), 64'(0));
    check_output("start_mthi_res_lo", 64'(got_lo), 64'(32'h00000019));

    // Reset mid-run aborts, then a fresh operation completes.
    apply_stimulus(OP_MULT, 32'hFFFFFFFD, 32'd5);
    repeat (11) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_output("abort_busy", 64'(busy), 64'(0));
    check_output("abort_done", 64'(done), 64'(0));
    check_output("abort_hi", 64'(hi), 64'(0));
    check_output("abort_lo", 64'(lo), 64'(0));
    repeat (40) begin
      @(negedge clock);
      if (done) check_output("abort_stray_done", 64'(done), 64'(0));
    end
    apply_stimulus(OP_MULTU, 32'd6, 32'd7);
    wait_done(0, lat, busy_n, got_hi, got_lo);
    check_output("after_abort_latency", 64'(lat), 64'(LAT_FULL));
    check_output("after_abort_hi", 64'(got_hi), 64'(0));
    check_output("after_abort_lo", 64'(got_lo), 64'(32'h0000002A));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
